lea_key_sched_ctrl: RTL and testbench
=====================================

Name: lea_key_sched_ctrl

Overview:
Sequencer for the LEA-128 key schedule. It loads a 128-bit master key and steps through the rounds. Each round it combines the key state with the four 32-bit delta constants from the key-constant generator (its E0..E3 outputs). It emits one 192-bit round key per round to the encryption datapath over a valid/ready handshake, with backpressure.

Parameters:
NUM_ROUNDS, 24, number of round keys generated per key load (24 = LEA-128); legal range 1..32
RND_W, 5, width of the round counter and rk_round; must satisfy 2^RND_W >= NUM_ROUNDS

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
start  input  1  single-cycle request to begin a schedule; sampled only in IDLE
key  input  128  master key; key[31:0]=K0, key[63:32]=K1, key[95:64]=K2, key[127:96]=K3; sampled on accepted start
delta0..delta3  input  32 each  key constants from the generator (E0..E3); must be stable while busy
rk_valid  output  1  round key on rk is valid
rk_ready  input  1  downstream accepts rk this cycle
rk  output  192  round key {RK5,RK4,RK3,RK2,RK1,RK0}, with RK0 in rk[31:0]
rk_round  output  RND_W  index i of the round key currently on rk
busy  output  1  schedule in progress
done  output  1  one-cycle pulse after the last round key is accepted

Behaviour:
- Reset (async, rst_n=0): state=IDLE. rk_valid=0, rk=0, rk_round=0, busy=0, done=0. T0..T3 cleared.
- States are IDLE, GEN and HOLD.
- IDLE:
  - start=1 loads Tj=Kj (j=0..3), round counter i=0, busy=1, then goes to GEN.
  - start=0: stay in IDLE.
- GEN (exactly one cycle), with d = delta[i mod 4]:
  - T0 <= ROL1(T0 + ROL(d, i mod 32))
  - T1 <= ROL3(T1 + ROL(d, (i+1) mod 32))
  - T2 <= ROL6(T2 + ROL(d, (i+2) mod 32))
  - T3 <= ROL11(T3 + ROL(d, (i+3) mod 32))
  - All additions are mod 2^32.
  - rk is registered from the new values: RK0=T0', RK1=T1', RK2=T2', RK3=T1', RK4=T3', RK5=T1'.
  - rk_round <= i, rk_valid <= 1, next state HOLD.
- HOLD:
  - rk, rk_round and rk_valid are held stable while rk_ready=0, with no timeout.
  - On rk_valid & rk_ready: rk_valid <= 0 next cycle.
  - If i == NUM_ROUNDS-1: busy <= 0, done <= 1 for one cycle, go to IDLE.
  - Otherwise: i <= i+1, go to GEN.
- Latency:
  - Accepted start to first rk_valid=1 is 2 cycles.
  - Handshake to next rk_valid=1 is 2 cycles, so peak throughput is one round key per 2 cycles.
- start while busy is ignored and has no effect on state or outputs.
- start in the same cycle that done is asserted is ignored. start on the cycle after done is accepted normally.
- rk_ready while rk_valid=0 is ignored.
- rk keeps the last round key after done until the next GEN cycle.
- Async reset mid-schedule aborts immediately: all outputs return to reset values and no done is produced.
- rk_round wraps correctly at NUM_ROUNDS-1. The counter never exceeds NUM_ROUNDS-1.

Test Plan:
1. Basic key-0 check. Reset, deltas = c3efe9db, 44626b02, 79e27c8a, 78df30ec, key K0..K3 = 3c2d1e0f, 78695a4b, b4a59687, f0e1d2c3, start, rk_ready tied 1 -> first rk_valid 2 cycles after start; rk_round=0; RK0..RK5 = 003a0fd4, 02497010, 194f7db1, 02497010, 090d0883, 02497010.
2. Full schedule. Same setup run to completion -> exactly 24 handshakes with rk_round 0..23 in order; all 24 RKs match the golden model; done pulses once, 1 cycle after the round-23 handshake; busy falls with done.
3. Backpressure. Hold rk_ready=0 for 7 cycles on round 5 -> rk, rk_round=5 and rk_valid stay constant; no T update; resume yields the correct round 6.
4. Start while busy. Pulse start with a different key at round 10 -> ignored; remaining round keys still match the original key; a single done.
5. Reset mid-operation. Assert rst_n=0 asynchronously (between clock edges) during HOLD of round 3 -> rk_valid=0, busy=0, rk=0 immediately; a new start afterward produces the correct round 0.
6. Back-to-back start. start on the cycle after done with key=0 -> new schedule begins; round 0 matches the golden model for the zero key.

Source files
------------

// File: rtl/lea_key_sched_ctrl_if.sv
// Bundle between the LEA-128 key-schedule sequencer and its neighbours:
// master key and delta constants in, 192-bit round keys out over valid/ready.
interface lea_key_sched_ctrl_if #(
  parameter int RND_W = 5
);
  logic             start;
  logic [127:0]     key;
  logic [31:0]      delta0;
  logic [31:0]      delta1;
  logic [31:0]      delta2;
  logic [31:0]      delta3;
  logic             rk_valid;
  logic             rk_ready;
  logic [191:0]     rk;
  logic [RND_W-1:0] rk_round;
  logic             busy;
  logic             done;

  // Handshake: a round key transfers on every rising edge where rk_valid and
  // rk_ready are both high; rk/rk_round stay stable while rk_valid waits.
  modport master (
    output start, key, delta0, delta1, delta2, delta3, rk_ready,
    input  rk_valid, rk, rk_round, busy, done
  );

  modport slave (
    input  start, key, delta0, delta1, delta2, delta3, rk_ready,
    output rk_valid, rk, rk_round, busy, done
  );
endinterface

// File: rtl/lea_key_sched_ctrl.sv
// LEA-128 key-schedule sequencer: loads a master key, produces one 192-bit
// round key per round from the delta constants, and hands it off via valid/ready.
module lea_key_sched_ctrl #(
  parameter int NUM_ROUNDS = 24,
  parameter int RND_W      = 5
) (
  input  logic                       clk,
  input  logic                       rst_n,
  lea_key_sched_ctrl_if.slave        bus,
  output logic [1:0]                 o_dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_GEN  = 2'd1,
    S_HOLD = 2'd2
  } state_t;

  localparam logic [RND_W-1:0] LAST_RND = RND_W'(NUM_ROUNDS - 1);

  state_t           r_state;
  logic [31:0]      r_t0;
  logic [31:0]      r_t1;
  logic [31:0]      r_t2;
  logic [31:0]      r_t3;
  logic [RND_W-1:0] r_i;
  logic [191:0]     r_rk;
  logic [RND_W-1:0] r_rk_round;
  logic             r_rk_valid;
  logic             r_busy;
  logic             r_done;

  logic [4:0]       w_sh;
  logic [1:0]       w_sel;
  logic [31:0]      w_d;
  logic [31:0]      w_t0n;
  logic [31:0]      w_t1n;
  logic [31:0]      w_t2n;
  logic [31:0]      w_t3n;

  // A shift by 32 yields zero, so n == 0 correctly returns x unchanged.
  function automatic logic [31:0] rol(input logic [31:0] x, input logic [4:0] n);
    return (x << n) | (x >> (6'd32 - {1'b0, n}));
  endfunction

  assign w_sh  = 5'(r_i);
  assign w_sel = 2'(r_i);

  always_comb begin
    w_d = bus.delta0;
    case (w_sel)
      2'd0:    w_d = bus.delta0;
      2'd1:    w_d = bus.delta1;
      2'd2:    w_d = bus.delta2;
      default: w_d = bus.delta3;
    endcase
  end

  assign w_t0n = rol(r_t0 + rol(w_d, w_sh),         5'd1);
  assign w_t1n = rol(r_t1 + rol(w_d, w_sh + 5'd1),  5'd3);
  assign w_t2n = rol(r_t2 + rol(w_d, w_sh + 5'd2),  5'd6);
  assign w_t3n = rol(r_t3 + rol(w_d, w_sh + 5'd3),  5'd11);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_t0       <= '0;
      r_t1       <= '0;
      r_t2       <= '0;
      r_t3       <= '0;
      r_i        <= '0;
      r_rk       <= '0;
      r_rk_round <= '0;
      r_rk_valid <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_done <= 1'b0;
          // A start that coincides with the done pulse is dropped.
          if (bus.start && !r_done) begin
            r_t0    <= bus.key[31:0];
            r_t1    <= bus.key[63:32];
            r_t2    <= bus.key[95:64];
            r_t3    <= bus.key[127:96];
            r_i     <= '0;
            r_busy  <= 1'b1;
            r_state <= S_GEN;
          end
        end
        S_GEN: begin
          r_t0       <= w_t0n;
          r_t1       <= w_t1n;
          r_t2       <= w_t2n;
          r_t3       <= w_t3n;
          r_rk       <= {w_t1n, w_t3n, w_t1n, w_t2n, w_t1n, w_t0n};
          r_rk_round <= r_i;
          r_rk_valid <= 1'b1;
          r_state    <= S_HOLD;
        end
        S_HOLD: begin
          if (bus.rk_ready) begin
            r_rk_valid <= 1'b0;
            if (r_i == LAST_RND) begin
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
              r_state <= S_IDLE;
            end else begin
              r_i     <= r_i + RND_W'(1);
              r_state <= S_GEN;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.rk_valid = r_rk_valid;
  assign bus.rk       = r_rk;
  assign bus.rk_round = r_rk_round;
  assign bus.busy     = r_busy;
  assign bus.done     = r_done;
  assign o_dbg_state  = r_state;

endmodule

// File: tb/tb_lea_key_sched_ctrl.sv
// Bench for lea_key_sched_ctrl: golden vectors, randomized schedules with
// backpressure, and hand-built corner sequences checked against a key-schedule model.
module tb_lea_key_sched_ctrl;
  localparam int NR = 24;
  localparam int RW = 5;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  lea_key_sched_ctrl_if #(.RND_W(RW)) bus();
  logic [1:0] dbg_state;

  lea_key_sched_ctrl #(.NUM_ROUNDS(NR), .RND_W(RW)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .bus         (bus),
    .o_dbg_state (dbg_state)
  );

  int total = 0;
  int bad = 0;
  int done_cnt = 0;
  int hs_cnt = 0;
  bit prev_last_hs = 1'b0;
  logic [196:0] exp_q[$];

  typedef struct {
    logic [127:0] key;
    logic [127:0] dl;
    logic [191:0] exp_rk0;
  } vec_t;
  vec_t vecs[3];

  localparam logic [127:0] G_KEY = {32'hf0e1d2c3, 32'hb4a59687, 32'h78695a4b, 32'h3c2d1e0f};
  localparam logic [127:0] G_DL  = {32'h78df30ec, 32'h79e27c8a, 32'h44626b02, 32'hc3efe9db};

  task automatic check(input string name, input logic [191:0] act, input logic [191:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] rol32(input logic [31:0] x, input int n);
    int m;
    m = n % 32;
    if (m == 0) return x;
    return (x << m) | (x >> (32 - m));
  endfunction

  // Round key r computed from scratch: run the T-state recurrence r+1 times.
  function automatic logic [191:0] model_rk(input logic [127:0] k, input logic [127:0] dl, input int r);
    logic [31:0] t[4];
    logic [31:0] dd;
    for (int j = 0; j < 4; j++) t[j] = k[32*j +: 32];
    for (int i = 0; i <= r; i++) begin
      dd = dl[32*(i%4) +: 32];
      t[0] = rol32(t[0] + rol32(dd, i),     1);
      t[1] = rol32(t[1] + rol32(dd, i + 1), 3);
      t[2] = rol32(t[2] + rol32(dd, i + 2), 6);
      t[3] = rol32(t[3] + rol32(dd, i + 3), 11);
    end
    return {t[1], t[3], t[1], t[2], t[1], t[0]};
  endfunction

  // Monitor: a handshake at the coming rising edge is visible here.
  always @(negedge clk) begin
    logic [196:0] e;
    if (rst_n) begin
      if (prev_last_hs) begin
        check("done_after_last", 192'(bus.done), 192'(1));
        check("busy_with_done", 192'(bus.busy), 192'(0));
      end else begin
        check("no_spurious_done", 192'(bus.done), 192'(0));
      end
      if (bus.done) done_cnt++;
      if (bus.rk_valid) check("round_range", 192'(int'(bus.rk_round) < NR), 192'(1));
      prev_last_hs = bus.rk_valid && bus.rk_ready && (int'(bus.rk_round) == NR - 1);
      if (bus.rk_valid && bus.rk_ready) begin
        hs_cnt++;
        if (exp_q.size() == 0) begin
          check("hs_unexpected", 192'(exp_q.size()), 192'(1));
        end else begin
          e = exp_q.pop_front();
          check("hs_round", 192'(bus.rk_round), 192'(e[196:192]));
          check("hs_rk", bus.rk, e[191:0]);
        end
      end
    end else begin
      prev_last_hs = 1'b0;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_sched(input logic [127:0] k, input logic [127:0] dl);
    bus.key = k;
    {bus.delta3, bus.delta2, bus.delta1, bus.delta0} = dl;
    bus.start = 1'b1;
    for (int r = 0; r < NR; r++) exp_q.push_back({5'(r), model_rk(k, dl, r)});
    tick();
    bus.start = 1'b0;
  endtask

  // Drives rk_ready until done is seen; returns in the done cycle.
  task automatic serve(input int stall_round, input int stall_len, input int inject_round,
                       input bit rand_ready, input int budget);
    int stalled;
    bit injected;
    bit ok;
    logic [191:0] snap_rk;
    logic [RW-1:0] snap_r;
    stalled = 0; injected = 1'b0; ok = 1'b0; snap_rk = '0; snap_r = '0;
    for (int c = 0; c < budget; c++) begin
      if (bus.done) begin
        ok = 1'b1;
        break;
      end
      bus.start = 1'b0;
      if (bus.rk_valid && int'(bus.rk_round) == stall_round && stalled < stall_len) begin
        if (stalled == 0) begin
          snap_rk = bus.rk;
          snap_r  = bus.rk_round;
        end else begin
          check("stall_rk", bus.rk, snap_rk);
          check("stall_round", 192'(bus.rk_round), 192'(snap_r));
          check("stall_valid", 192'(bus.rk_valid), 192'(1));
        end
        stalled++;
        bus.rk_ready = 1'b0;
      end else begin
        bus.rk_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      end
      if (bus.rk_valid && int'(bus.rk_round) == inject_round && !injected) begin
        injected = 1'b1;
        bus.start = 1'b1;
        bus.key = ~bus.key;
      end
      tick();
    end
    bus.start = 1'b0;
    check("done_timeout", 192'(ok), 192'(1));
  endtask

  initial begin
    int hs0;
    int d0;
    logic [127:0] rk_key;
    logic [127:0] rk_dl;

    bus.start = 1'b0;
    bus.key = '0;
    {bus.delta3, bus.delta2, bus.delta1, bus.delta0} = '0;
    bus.rk_ready = 1'b0;

    // Reset state
    #2 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_valid", 192'(bus.rk_valid), 192'(0));
    check("rst_rk", bus.rk, 192'(0));
    check("rst_round", 192'(bus.rk_round), 192'(0));
    check("rst_busy", 192'(bus.busy), 192'(0));
    check("rst_done", 192'(bus.done), 192'(0));
    check("rst_state", 192'(dbg_state), 192'(0));
    rst_n = 1'b1;
    tick();

    vecs[0] = '{G_KEY, G_DL, {32'h02497010, 32'h090d0883, 32'h02497010,
                              32'h194f7db1, 32'h02497010, 32'h003a0fd4}};
    vecs[1] = '{128'h0, G_DL, model_rk(128'h0, G_DL, 0)};
    vecs[2] = '{128'h0123456789abcdeffedcba9876543210, 128'hdeadbeef_00000001_80000000_a5a5a5a5,
                model_rk(128'h0123456789abcdeffedcba9876543210,
                         128'hdeadbeef_00000001_80000000_a5a5a5a5, 0)};

    // Golden first round key and full schedules
    for (int v = 0; v < 3; v++) begin
      hs0 = hs_cnt; d0 = done_cnt;
      bus.rk_ready = 1'b1;
      start_sched(vecs[v].key, vecs[v].dl);
      check("gen_busy", 192'(bus.busy), 192'(1));
      check("gen_valid_low", 192'(bus.rk_valid), 192'(0));
      check("gen_state", 192'(dbg_state), 192'(1));
      tick();
      check("first_valid", 192'(bus.rk_valid), 192'(1));
      check("first_round", 192'(bus.rk_round), 192'(0));
      check("first_rk", bus.rk, vecs[v].exp_rk0);
      serve(-1, 0, -1, v != 0, 400);
      tick();
      check("sched_hs", 192'(hs_cnt - hs0), 192'(NR));
      check("sched_done", 192'(done_cnt - d0), 192'(1));
      check("sched_busy_low", 192'(bus.busy), 192'(0));
      check("rk_kept", bus.rk, model_rk(vecs[v].key, vecs[v].dl, NR - 1));
    end

    // Backpressure on round 5, then start raised in the done cycle
    hs0 = hs_cnt; d0 = done_cnt;
    start_sched(G_KEY, G_DL);
    serve(5, 7, -1, 1'b0, 400);
    bus.start = 1'b1;
    bus.key = '0;
    tick();
    bus.start = 1'b0;
    check("done_start_busy", 192'(bus.busy), 192'(0));
    check("done_start_state", 192'(dbg_state), 192'(0));
    tick();
    check("done_start_busy2", 192'(bus.busy), 192'(0));
    check("done_start_valid", 192'(bus.rk_valid), 192'(0));
    check("bp_hs", 192'(hs_cnt - hs0), 192'(NR));
    check("bp_done", 192'(done_cnt - d0), 192'(1));

    // Start while busy at round 10
    hs0 = hs_cnt; d0 = done_cnt;
    start_sched(G_KEY, G_DL);
    serve(-1, 0, 10, 1'b1, 400);
    tick();
    check("inj_hs", 192'(hs_cnt - hs0), 192'(NR));
    check("inj_done", 192'(done_cnt - d0), 192'(1));

    // Asynchronous reset during HOLD of round 3
    d0 = done_cnt;
    start_sched(G_KEY, G_DL);
    for (int c = 0; c < 200; c++) begin
      if (bus.rk_valid && int'(bus.rk_round) == 3) break;
      bus.rk_ready = 1'b1;
      tick();
    end
    bus.rk_ready = 1'b0;
    tick();
    check("abort_in_hold", 192'(dbg_state), 192'(2));
    check("abort_round", 192'(bus.rk_round), 192'(3));
    #3 rst_n = 1'b0;
    #1;
    check("abort_valid", 192'(bus.rk_valid), 192'(0));
    check("abort_busy", 192'(bus.busy), 192'(0));
    check("abort_rk", bus.rk, 192'(0));
    check("abort_rk_round", 192'(bus.rk_round), 192'(0));
    exp_q.delete();
    tick();
    rst_n = 1'b1;
    tick();
    check("abort_no_done", 192'(done_cnt - d0), 192'(0));
    bus.rk_ready = 1'b1;
    start_sched(G_KEY, G_DL);
    tick();
    check("post_rst_round", 192'(bus.rk_round), 192'(0));
    check("post_rst_rk", bus.rk, vecs[0].exp_rk0);
    serve(-1, 0, -1, 1'b1, 400);
    tick();

    // Back-to-back: start on the cycle after done with the zero key
    hs0 = hs_cnt; d0 = done_cnt;
    bus.rk_ready = 1'b1;
    start_sched(128'h0, G_DL);
    check("b2b_busy", 192'(bus.busy), 192'(1));
    tick();
    check("b2b_valid", 192'(bus.rk_valid), 192'(1));
    check("b2b_rk0", bus.rk, model_rk(128'h0, G_DL, 0));
    serve(-1, 0, -1, 1'b1, 400);
    tick();
    check("b2b_hs", 192'(hs_cnt - hs0), 192'(NR));
    check("b2b_done", 192'(done_cnt - d0), 192'(1));

    // Randomized keys and deltas with random backpressure
    for (int n = 0; n < 4; n++) begin
      rk_key = {$urandom, $urandom, $urandom, $urandom};
      rk_dl  = {$urandom, $urandom, $urandom, $urandom};
      hs0 = hs_cnt; d0 = done_cnt;
      start_sched(rk_key, rk_dl);
      serve($urandom_range(0, NR - 1), $urandom_range(1, 5), -1, 1'b1, 600);
      tick();
      check("rnd_hs", 192'(hs_cnt - hs0), 192'(NR));
      check("rnd_done", 192'(done_cnt - d0), 192'(1));
    end

    repeat (2) tick();
    check("queue_empty", 192'(exp_q.size()), 192'(0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end
endmodule
